alu_arbiter: RTL and testbench

- Shares one combinational C_ALU instance (3-bit op, 16-bit in0/in1/out) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshake on both the request and response sides.
- Operands are latched, the ALU is driven from registers, and the result is registered and returned tagged with the requester ID.
- Sits between decode/issue sources (e.g. integer pipe, address-gen) and the shared ALU.

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Grants in IDLE, drives the ALU from registers in EXEC and holds the tagged result in RESP.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [3*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic [2:0]                 alu_op,
    output logic [WIDTH-1:0]           alu_in0,
    output logic [WIDTH-1:0]           alu_in1,
    input  logic [WIDTH-1:0]           alu_out,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;

    // Requester index reached after stepping 'offset' places past 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    always_comb begin
        grant_idx   = last_grant;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_valid[rr_index(last_grant, k)]) begin
                grant_idx   = rr_index(last_grant, k);
                grant_found = 1'b1;
            end
        end
    end

    assign accept = (state == IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only the granted slice is ever sampled, so idle requesters' operands never reach the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op     <= '0;
            alu_in0    <= '0;
            alu_in1    <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                alu_op     <= req_op[3*int'(grant_idx) +: 3];
                alu_in0    <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
                alu_in1    <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
                rsp_id     <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_out;
                rsp_valid <= 1'b1;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference checked every cycle, plus
// directed scenarios with literal expected results.
module tb_alu_arbiter;

    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [3*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic [2:0]               alu_op;
    logic [WIDTH-1:0]         alu_in0;
    logic [WIDTH-1:0]         alu_in1;
    logic [WIDTH-1:0]         alu_out;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return a - b;
            3'd5: return ~(a & b);
            3'd6: return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    // Shared combinational ALU
    always_comb alu_out = alu_ref(alu_op, alu_in0, alu_in1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_phase 0 = free, 1 = computing, 2 = result offered
    int               m_phase;
    int               m_last;
    int               m_id;
    logic [WIDTH-1:0] m_data, m_pend, m_a, m_b;
    logic [2:0]       m_op;

    function automatic int rr_pick();
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req_valid[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int w;
        if (!rst_n) begin
            m_phase = 0; m_last = NUM_REQ - 1; m_id = 0;
            m_data = '0; m_pend = '0; m_a = '0; m_b = '0; m_op = '0;
        end else begin
            case (m_phase)
                0: begin
                    w = rr_pick();
                    if (w >= 0) begin
                        m_op   = req_op[3*w +: 3];
                        m_a    = req_a[WIDTH*w +: WIDTH];
                        m_b    = req_b[WIDTH*w +: WIDTH];
                        m_pend = alu_ref(m_op, m_a, m_b);
                        m_id   = w;
                        m_last = w;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_data  = m_pend;
                    m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        logic [NUM_REQ-1:0] er;
        int p;
        if (rst_n === 1'b1) begin
            er = '0;
            p  = rr_pick();
            if (m_phase == 0 && p >= 0) er[p] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(er));
            check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            check("busy",      32'(busy),      32'(m_phase != 0));
            check("rsp_data",  32'(rsp_data),  32'(m_data));
            check("rsp_id",    32'(rsp_id),    32'(m_id));
            check("alu_op",    32'(alu_op),    32'(m_op));
            check("alu_in0",   32'(alu_in0),   32'(m_a));
            check("alu_in1",   32'(alu_in1),   32'(m_b));
        end
    end

    // Completed responses in handshake order
    int               q_id[$];
    logic [WIDTH-1:0] q_data[$];

    always @(posedge clk) begin
        if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
            q_id.push_back(int'(rsp_id));
            q_data.push_back(rsp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        req_op[3*i +: 3]     = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q_id.delete();
        q_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] op_exp [8];
        op_exp = '{16'hFFEF, 16'hFFF0, 16'hFFFF, 16'h000F, 16'h000F, 16'h000F, 16'h0000, 16'hFFF0};

        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        tick();
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset alu_in0",   32'(alu_in0),   32'd0);
        check("reset rsp_data",  32'(rsp_data),  32'd0);
        tick();
        rst_n = 1'b1;

        // Single add request
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 16'h0001, 16'h0003);
        req_valid = 2'b01;
        #1 check("single req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single exec rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("single rsp_valid", 32'(rsp_valid), 32'd1);
        check("single rsp_data",  32'(rsp_data),  32'h0004);
        check("single rsp_id",    32'(rsp_id),    32'd0);
        tick();
        check("single back idle", 32'(busy), 32'd0);

        // Round-robin fairness
        do_reset();
        set_req(0, 3'b100, 16'h0001, 16'h0003);
        set_req(1, 3'b100, 16'hFFFF, 16'hFFF0);
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) tick();
        req_valid = '0;
        check("rr count", 32'(q_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < q_id.size(); i++) begin
            check("rr id",   32'(q_id[i]),   32'(i % 2));
            check("rr data", 32'(q_data[i]), (i % 2 == 0) ? 32'hFFFE : 32'h000F);
        end
        tick(); tick(); tick();

        // Backpressure
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, 3'b001, 16'h0001, 16'hFFFC);
        req_valid = 2'b10;
        tick();
        set_req(0, 3'b000, 16'h1111, 16'h2222);
        req_valid = 2'b01;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_data",  32'(rsp_data),  32'h0000);
            check("bp rsp_id",    32'(rsp_id),    32'd1);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp busy",      32'(busy),      32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp release busy",      32'(busy),      32'd0);
        check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        tick();

        // Reset during EXEC discards the request
        do_reset();
        set_req(1, 3'b011, 16'h00FF, 16'h0F0F);
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst alu_in0",   32'(alu_in0),   32'd0);
        check("rst alu_op",    32'(alu_op),    32'd0);
        check("rst busy",      32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        set_req(0, 3'b000, 16'h0002, 16'h0003);
        set_req(1, 3'b011, 16'h00FF, 16'h0F0F);
        req_valid = 2'b11;
        #1 check("rst first grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        check("rst rsp count", 32'(q_id.size()), 32'd1);
        if (q_id.size() > 0) begin
            check("rst rsp id",   32'(q_id[0]),   32'd0);
            check("rst rsp data", 32'(q_data[0]), 32'h0005);
        end

        // All eight ops through requester 0
        do_reset();
        for (int op = 0; op < 8; op++) begin
            set_req(0, 3'(op), 16'hFFFF, 16'hFFF0);
            req_valid = 2'b01;
            tick();
            req_valid = '0;
            tick(); tick();
        end
        check("ops count", 32'(q_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            check("ops data", 32'(q_data[i]), 32'(op_exp[i]));
        end

        // Withdrawn request while a result is pending
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 16'h1234, 16'h1111);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        set_req(1, 3'b000, 16'h0005, 16'h0005);
        req_valid = 2'b10;
        #1 check("wd req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = '0;
        check("wd rsp_data", 32'(rsp_data), 32'h2345);
        check("wd rsp_id",   32'(rsp_id),   32'd0);
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        check("wd rsp count", 32'(q_id.size()), 32'd1);
        if (q_id.size() > 0) begin
            check("wd rsp id",   32'(q_id[0]),   32'd0);
            check("wd rsp data", 32'(q_data[0]), 32'h2345);
        end
        check("wd idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
